// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package mem_pkg;

  // Byte-enable width of the 32-bit data memory port
  localparam int BE_W = 4;

  // func3 encodings for load/store access size and signedness
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  // Stores only know SB/SH/SW, loads add the unsigned variants;
  // every other encoding falls back to a full word access.
  function automatic acc_size_t f3_size(input logic [2:0] f3, input logic is_store);
    acc_size_t sz;
    sz = SZ_W;
    if (f3 == F3_B || (!is_store && f3 == F3_BU)) begin
      sz = SZ_B;
    end else if (f3 == F3_H || (!is_store && f3 == F3_HU)) begin
      sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Per-address lane logic: store byte enables and replicated write data,
// load byte/half extraction with sign or zero extension, and the
// natural-alignment check for the access size.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]      func3,
  input  logic            is_store,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     st_data,
  input  logic [31:0]     ld_word,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata,
  output logic [31:0]     ld_data,
  output logic            misalign
);

  acc_size_t   size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        zext;

  // Lane selection and extension for the decoded access size
  always_comb begin
    size     = f3_size(func3, is_store);
    zext     = func3[2];
    be       = 4'b1111;
    wdata    = st_data;
    ld_data  = ld_word;
    misalign = 1'b0;
    case (addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (size)
      SZ_B: begin
        wdata   = {4{st_data[7:0]}};
        ld_data = zext ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        if (is_store) be = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        misalign = addr_lo[0];
        wdata    = {2{st_data[15:0]}};
        ld_data  = zext ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        if (is_store) be = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: consumes the EX/MEM bundle, runs one or two data-memory
// accesses over a req/ack handshake while stalling upstream, and
// registers the MEM/WB result bundle.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int RD_W = 6,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            me_valid,
  input  logic [XLEN-1:0] me_regs_data2,
  input  logic [XLEN-1:0] me_alu_o,
  input  logic [XLEN-1:0] me_alu_o2,
  input  logic            me_mop_en,
  input  logic [RD_W-1:0] me_rd,
  input  logic            me_mem_read,
  input  logic            me_mem_write,
  input  logic            me_mem2reg,
  input  logic            me_regs_write,
  input  logic [2:0]      me_func3_code,
  output logic            me_stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [BE_W-1:0] dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_regs_write,
  output logic            wb_mem2reg,
  output logic [XLEN-1:0] wb_alu_o,
  output logic [XLEN-1:0] wb_mem_data,
  output logic [XLEN-1:0] wb_mem_data2,
  output logic            wb_misalign
);

  lsu_state_t state_q, state_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
  logic [BE_W-1:0] dmem_be_q, dmem_be_d;
  logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic            wb_regs_write_q, wb_regs_write_d;
  logic            wb_mem2reg_q, wb_mem2reg_d;
  logic [XLEN-1:0] wb_alu_o_q, wb_alu_o_d;
  logic [XLEN-1:0] wb_mem_data_q, wb_mem_data_d;
  logic [XLEN-1:0] wb_mem_data2_q, wb_mem_data2_d;
  logic            wb_misalign_q, wb_misalign_d;
  logic [XLEN-1:0] data0_q, data0_d;

  logic            is_store, is_load, memop, misalign, final_access;
  logic [BE_W-1:0] be0, be1;
  logic [XLEN-1:0] wdata0, wdata1, ld0_raw, ld1_raw, ld0, ld1;
  logic            mis0, mis1;

  assign is_store     = me_mem_write;
  assign is_load      = me_mem_read & ~me_mem_write;
  assign memop        = me_valid & (me_mem_read | me_mem_write);
  assign misalign     = mis0 | (me_mop_en & mis1);
  assign final_access = (state_q == ACC1) | ((state_q == ACC0) & ~me_mop_en);
  assign ld0          = is_load ? ld0_raw : '0;
  assign ld1          = is_load ? ld1_raw : '0;

  lsu_align u_align0 (
    .func3    (me_func3_code),
    .is_store (is_store),
    .addr_lo  (me_alu_o[1:0]),
    .st_data  (me_regs_data2),
    .ld_word  (dmem_rdata),
    .be       (be0),
    .wdata    (wdata0),
    .ld_data  (ld0_raw),
    .misalign (mis0)
  );

  lsu_align u_align1 (
    .func3    (me_func3_code),
    .is_store (is_store),
    .addr_lo  (me_alu_o2[1:0]),
    .st_data  (me_regs_data2),
    .ld_word  (dmem_rdata),
    .be       (be1),
    .wdata    (wdata1),
    .ld_data  (ld1_raw),
    .misalign (mis1)
  );

  // Next-state, memory request and writeback bundle; wb_valid is a one-cycle pulse
  always_comb begin
    state_d         = state_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_be_d       = dmem_be_q;
    dmem_wdata_d    = dmem_wdata_q;
    wb_valid_d      = 1'b0;
    wb_rd_d         = wb_rd_q;
    wb_regs_write_d = wb_regs_write_q;
    wb_mem2reg_d    = wb_mem2reg_q;
    wb_alu_o_d      = wb_alu_o_q;
    wb_mem_data_d   = wb_mem_data_q;
    wb_mem_data2_d  = wb_mem_data2_q;
    wb_misalign_d   = wb_misalign_q;
    data0_d         = data0_q;
    me_stall        = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop && !misalign) begin
          me_stall     = 1'b1;
          state_d      = ACC0;
          dmem_req_d   = 1'b1;
          dmem_we_d    = is_store;
          dmem_addr_d  = {me_alu_o[XLEN-1:2], 2'b00};
          dmem_be_d    = be0;
          dmem_wdata_d = wdata0;
        end else begin
          wb_valid_d      = memop ? 1'b1 : me_valid;
          wb_rd_d         = me_rd;
          wb_regs_write_d = memop ? 1'b0 : me_regs_write;
          wb_mem2reg_d    = me_mem2reg;
          wb_alu_o_d      = me_alu_o;
          wb_mem_data_d   = '0;
          wb_mem_data2_d  = '0;
          wb_misalign_d   = memop;
        end
      end
      ACC0, ACC1: begin
        me_stall = ~(dmem_ack & final_access);
        if (dmem_ack) begin
          if (!final_access) begin
            data0_d      = ld0;
            state_d      = ACC1;
            dmem_addr_d  = {me_alu_o2[XLEN-1:2], 2'b00};
            dmem_be_d    = be1;
            dmem_wdata_d = wdata1;
          end else begin
            state_d         = IDLE;
            dmem_req_d      = 1'b0;
            wb_valid_d      = 1'b1;
            wb_rd_d         = me_rd;
            wb_regs_write_d = me_regs_write;
            wb_mem2reg_d    = me_mem2reg;
            wb_alu_o_d      = me_alu_o;
            wb_mem_data_d   = (state_q == ACC0) ? ld0 : data0_q;
            wb_mem_data2_d  = (state_q == ACC1) ? ld1 : '0;
            wb_misalign_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) me_stall = 1'b0;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_be_q       <= '0;
      dmem_wdata_q    <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_regs_write_q <= 1'b0;
      wb_mem2reg_q    <= 1'b0;
      wb_alu_o_q      <= '0;
      wb_mem_data_q   <= '0;
      wb_mem_data2_q  <= '0;
      wb_misalign_q   <= 1'b0;
      data0_q         <= '0;
    end else begin
      state_q         <= state_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_be_q       <= dmem_be_d;
      dmem_wdata_q    <= dmem_wdata_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_regs_write_q <= wb_regs_write_d;
      wb_mem2reg_q    <= wb_mem2reg_d;
      wb_alu_o_q      <= wb_alu_o_d;
      wb_mem_data_q   <= wb_mem_data_d;
      wb_mem_data2_q  <= wb_mem_data2_d;
      wb_misalign_q   <= wb_misalign_d;
      data0_q         <= data0_d;
    end
  end

  assign dmem_req      = dmem_req_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_be       = dmem_be_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_regs_write = wb_regs_write_q;
  assign wb_mem2reg    = wb_mem2reg_q;
  assign wb_alu_o      = wb_alu_o_q;
  assign wb_mem_data   = wb_mem_data_q;
  assign wb_mem_data2  = wb_mem_data2_q;
  assign wb_misalign   = wb_misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed vectors push expected memory
// requests and writeback bundles; monitors compare whenever the DUT presents them.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        me_valid;
  logic [31:0] me_regs_data2, me_alu_o, me_alu_o2;
  logic        me_mop_en;
  logic [5:0]  me_rd;
  logic        me_mem_read, me_mem_write, me_mem2reg, me_regs_write;
  logic [2:0]  me_func3_code;
  logic        me_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        wb_valid, wb_regs_write, wb_mem2reg, wb_misalign;
  logic [5:0]  wb_rd;
  logic [31:0] wb_alu_o, wb_mem_data, wb_mem_data2;

  logic        resp_ack, force_ack;
  assign dmem_ack = resp_ack | force_ack;

  typedef struct {
    logic wr; logic rdn; logic mop; logic [2:0] f3; logic [5:0] rd; logic rw; logic m2r;
    logic [31:0] alu; logic [31:0] alu2; logic [31:0] data2;
    int nacc; int d0; int d1; logic [31:0] r0; logic [31:0] r1;
    logic [31:0] a0; logic [3:0] be0; logic [31:0] wd0;
    logic [31:0] a1; logic [3:0] be1; logic [31:0] wd1;
    logic [31:0] md; logic [31:0] md2; logic mis;
  } vec_t;

  typedef struct {
    logic [5:0] rd; logic rw; logic m2r; logic [31:0] alu;
    logic [31:0] md; logic [31:0] md2; logic mis; int cyc;
  } exp_wb_t;

  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
  } exp_dm_t;

  exp_wb_t wb_q[$];
  exp_dm_t dm_q[$];
  int n_vec, n_err, cyc;
  int resp_delay[64];
  logic [31:0] resp_data[64];
  int wr_idx, rd_idx, wait_cnt;
  vec_t vecs[13];

  mem_stage_lsu #(.RD_W(6), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .me_valid(me_valid), .me_regs_data2(me_regs_data2),
    .me_alu_o(me_alu_o), .me_alu_o2(me_alu_o2), .me_mop_en(me_mop_en), .me_rd(me_rd),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write), .me_mem2reg(me_mem2reg),
    .me_regs_write(me_regs_write), .me_func3_code(me_func3_code), .me_stall(me_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regs_write(wb_regs_write),
    .wb_mem2reg(wb_mem2reg), .wb_alu_o(wb_alu_o), .wb_mem_data(wb_mem_data),
    .wb_mem_data2(wb_mem_data2), .wb_misalign(wb_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: acks the oldest queued response after its delay
  initial begin
    resp_ack = 1'b0;
    dmem_rdata = '0;
    rd_idx = 0;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (resp_ack) begin
        rd_idx++;
        wait_cnt = 0;
      end
      resp_ack = 1'b0;
      if (rst) begin
        rd_idx = wr_idx;
        wait_cnt = 0;
      end else if (dmem_req && rd_idx != wr_idx) begin
        if (wait_cnt >= resp_delay[rd_idx]) begin
          resp_ack = 1'b1;
          dmem_rdata = resp_data[rd_idx];
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitors: compare on every accepted memory access and every writeback
  initial begin
    exp_dm_t d;
    exp_wb_t e;
    forever begin
      @(negedge clk);
      if (dmem_req && dmem_ack) begin
        if (dm_q.size() == 0) begin
          checkOutput("dmem_unexpected", 32'd1, 32'd0);
        end else begin
          d = dm_q.pop_front();
          checkOutput("dmem_addr", dmem_addr, d.addr);
          checkOutput("dmem_we", {31'd0, dmem_we}, {31'd0, d.we});
          checkOutput("dmem_be", {28'd0, dmem_be}, {28'd0, d.be});
          if (d.we) checkOutput("dmem_wdata", dmem_wdata, d.wdata);
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          checkOutput("wb_unexpected", 32'd1, 32'd0);
        end else begin
          e = wb_q.pop_front();
          checkOutput("wb_rd", {26'd0, wb_rd}, {26'd0, e.rd});
          checkOutput("wb_regs_write", {31'd0, wb_regs_write}, {31'd0, e.rw});
          checkOutput("wb_mem2reg", {31'd0, wb_mem2reg}, {31'd0, e.m2r});
          checkOutput("wb_alu_o", wb_alu_o, e.alu);
          checkOutput("wb_mem_data", wb_mem_data, e.md);
          checkOutput("wb_mem_data2", wb_mem_data2, e.md2);
          checkOutput("wb_misalign", {31'd0, wb_misalign}, {31'd0, e.mis});
          checkOutput("wb_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int lat;
    exp_wb_t e;
    exp_dm_t d;
    logic [31:0] p_addr, p_wdata;
    logic [3:0] p_be;
    logic p_we, p_ack;
    lat = (v.nacc == 0) ? 0 : ((v.nacc == 1) ? 1 + v.d0 : 2 + v.d0 + v.d1);
    if (v.nacc >= 1) begin
      resp_delay[wr_idx] = v.d0;
      resp_data[wr_idx] = v.r0;
      wr_idx++;
      d = '{v.a0, v.wr, v.be0, v.wd0};
      dm_q.push_back(d);
    end
    if (v.nacc == 2) begin
      resp_delay[wr_idx] = v.d1;
      resp_data[wr_idx] = v.r1;
      wr_idx++;
      d = '{v.a1, v.wr, v.be1, v.wd1};
      dm_q.push_back(d);
    end
    e = '{v.rd, v.mis ? 1'b0 : v.rw, v.m2r, v.alu, v.md, v.md2, v.mis, cyc + lat + 1};
    wb_q.push_back(e);
    me_valid = 1'b1;
    me_mem_write = v.wr;
    me_mem_read = v.rdn;
    me_mop_en = v.mop;
    me_func3_code = v.f3;
    me_rd = v.rd;
    me_regs_write = v.rw;
    me_mem2reg = v.m2r;
    me_alu_o = v.alu;
    me_alu_o2 = v.alu2;
    me_regs_data2 = v.data2;
    p_addr = '0; p_wdata = '0; p_be = '0; p_we = 1'b0; p_ack = 1'b0;
    for (int n = 0; n <= lat; n++) begin
      @(negedge clk);
      checkOutput("me_stall", {31'd0, me_stall}, {31'd0, n != lat});
      if (n >= 1) begin
        checkOutput("dmem_req_held", {31'd0, dmem_req}, 32'd1);
        if (n >= 2 && !p_ack) begin
          checkOutput("dmem_addr_stable", dmem_addr, p_addr);
          checkOutput("dmem_be_stable", {28'd0, dmem_be}, {28'd0, p_be});
          checkOutput("dmem_wdata_stable", dmem_wdata, p_wdata);
          checkOutput("dmem_we_stable", {31'd0, dmem_we}, {31'd0, p_we});
        end
      end
      p_addr = dmem_addr; p_be = dmem_be; p_wdata = dmem_wdata; p_we = dmem_we;
      p_ack = dmem_ack;
    end
    @(posedge clk);
    #1;
    me_valid = 1'b0;
    me_mem_read = 1'b0;
    me_mem_write = 1'b0;
    me_mop_en = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; wr_idx = 0; force_ack = 1'b0;
    //          wr rd mop f3      rd     rw  m2r alu           alu2          data2          n  d0 d1 r0            r1            a0            be0      wd0           a1            be1      wd1           md            md2           mis
    vecs[0]  = '{0, 0, 0, 3'b000, 6'd5, 1, 0, 32'h0000_1234, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        0};
    vecs[1]  = '{0, 1, 0, 3'b000, 6'd7, 1, 1, 32'h0000_0103, 32'h0,        32'h0,         1, 0, 0, 32'h80FF_0000, 32'h0,       32'h0000_0100, 4'b1111, 32'h0,       32'h0,        4'b0000, 32'h0,        32'hFFFF_FF80, 32'h0,       0};
    vecs[2]  = '{0, 1, 0, 3'b100, 6'd7, 1, 1, 32'h0000_0103, 32'h0,        32'h0,         1, 0, 0, 32'h80FF_0000, 32'h0,       32'h0000_0100, 4'b1111, 32'h0,       32'h0,        4'b0000, 32'h0,        32'h0000_0080, 32'h0,       0};
    vecs[3]  = '{1, 0, 0, 3'b001, 6'd0, 0, 0, 32'h0000_0202, 32'h0,        32'h0000_ABCD, 1, 3, 0, 32'h0,        32'h0,        32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,      4'b0000, 32'h0,        32'h0,        32'h0,        0};
    vecs[4]  = '{0, 1, 1, 3'b010, 6'd9, 1, 1, 32'h0000_0040, 32'h0000_0080, 32'h0,        2, 0, 0, 32'h1111_2222, 32'h3333_4444, 32'h0000_0040, 4'b1111, 32'h0,      32'h0000_0080, 4'b1111, 32'h0,       32'h1111_2222, 32'h3333_4444, 0};
    vecs[5]  = '{0, 1, 0, 3'b010, 6'd3, 1, 1, 32'h0000_0102, 32'h0,        32'h0,         0, 0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        1};
    vecs[6]  = '{1, 0, 1, 3'b000, 6'd0, 0, 0, 32'h0000_0301, 32'h0000_0402, 32'h0000_125A, 2, 1, 0, 32'h0,       32'h0,        32'h0000_0300, 4'b0010, 32'h5A5A_5A5A, 32'h0000_0400, 4'b0100, 32'h5A5A_5A5A, 32'h0,     32'h0,        0};
    vecs[7]  = '{0, 1, 1, 3'b001, 6'd4, 1, 1, 32'h0000_0010, 32'h0000_0013, 32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        1};
    vecs[8]  = '{0, 1, 0, 3'b001, 6'd8, 1, 1, 32'h0000_0022, 32'h0,        32'h0,         1, 1, 0, 32'h8001_7FFF, 32'h0,       32'h0000_0020, 4'b1111, 32'h0,       32'h0,        4'b0000, 32'h0,        32'hFFFF_8001, 32'h0,       0};
    vecs[9]  = '{0, 1, 0, 3'b101, 6'd8, 1, 1, 32'h0000_0020, 32'h0,        32'h0,         1, 0, 0, 32'h8001_F00D, 32'h0,       32'h0000_0020, 4'b1111, 32'h0,       32'h0,        4'b0000, 32'h0,        32'h0000_F00D, 32'h0,       0};
    vecs[10] = '{1, 0, 0, 3'b011, 6'd0, 0, 0, 32'h0000_0030, 32'h0,        32'hDEAD_BEEF, 1, 2, 0, 32'h0,        32'h0,        32'h0000_0030, 4'b1111, 32'hDEAD_BEEF, 32'h0,      4'b0000, 32'h0,        32'h0,        32'h0,        0};
    vecs[11] = '{1, 1, 0, 3'b010, 6'd6, 1, 1, 32'h0000_0034, 32'h0,        32'h0102_0304, 1, 0, 0, 32'h0,        32'h0,        32'h0000_0034, 4'b1111, 32'h0102_0304, 32'h0,      4'b0000, 32'h0,        32'h0,        32'h0,        0};
    vecs[12] = '{1, 0, 0, 3'b001, 6'd0, 0, 0, 32'h0000_0203, 32'h0,        32'h0000_1111, 0, 0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        32'h0,        1};

    // Reset with an aligned load presented: stall must stay low under reset
    rst = 1'b1;
    me_valid = 1'b1; me_mem_read = 1'b1; me_mem_write = 1'b0; me_mop_en = 1'b0;
    me_func3_code = 3'b010; me_rd = 6'd1; me_regs_write = 1'b1; me_mem2reg = 1'b1;
    me_alu_o = 32'h0000_0100; me_alu_o2 = '0; me_regs_data2 = '0;
    @(negedge clk);
    checkOutput("rst_stall", {31'd0, me_stall}, 32'd0);
    @(negedge clk);
    checkOutput("rst_stall2", {31'd0, me_stall}, 32'd0);
    checkOutput("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_alu_o", wb_alu_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    me_valid = 1'b0; me_mem_read = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
    end

    // Reset while waiting for an ack: request dropped, late ack ignored
    me_valid = 1'b1; me_mem_read = 1'b1; me_mem_write = 1'b0; me_mop_en = 1'b0;
    me_func3_code = 3'b010; me_rd = 6'd2; me_regs_write = 1'b1; me_mem2reg = 1'b1;
    me_alu_o = 32'h0000_0500;
    @(negedge clk);
    checkOutput("acc0_stall", {31'd0, me_stall}, 32'd1);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checkOutput("acc0_req", {31'd0, dmem_req}, 32'd1);
      checkOutput("acc0_addr", dmem_addr, 32'h0000_0500);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_stall", {31'd0, me_stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    me_valid = 1'b0; me_mem_read = 1'b0;
    @(negedge clk);
    checkOutput("postrst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("postrst_addr", dmem_addr, 32'd0);
    checkOutput("postrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(posedge clk);
    #1;
    force_ack = 1'b1;
    @(negedge clk);
    checkOutput("lateack_stall", {31'd0, me_stall}, 32'd0);
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    checkOutput("lateack_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("lateack_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(vecs[0]);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("wb_queue_drained", wb_q.size(), 32'd0);
    checkOutput("dmem_queue_drained", dm_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
